// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM stage and MEM/WB pipeline register.
package mem_wb_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Word-wide D-cache request/stall bus between the MEM stage (master) and the cache (slave).
interface mem_wb_stage_if #(parameter int XLEN = 32);

  logic            ren;
  logic            wen;
  logic [29:0]     addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            stall;

  modport master (output ren, wen, addr, wdata, input rdata, stall);
  modport slave  (input ren, wen, addr, wdata, output rdata, stall);

endinterface

// File: rtl/mem_wb_stage_endian_swap.sv
// Pure combinational byte reversal of a data word.
module endian_swap #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);

  for (genvar b = 0; b < XLEN / 8; b++) begin : g_byte
    assign data_o[8*b +: 8] = data_i[XLEN-8-8*b +: 8];
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage of the RV32I pipeline: D-cache handshake FSM plus the MEM/WB register.
//   state  | meaning
//   IDLE   | no access in flight; a memop in EX/MEM launches one
//   ACCESS | request held on the cache bus until the cache drops stall
//   DONE   | access finished; stall released so EX/MEM advances
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter bit SWAP_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_mem_valid_i,
  input  logic             ex_mem_reg_write_i,
  input  logic             ex_mem_mem_read_i,
  input  logic             ex_mem_mem_write_i,
  input  logic             ex_mem_memto_reg_i,
  input  logic             ex_mem_jump_i,
  input  logic [4:0]       ex_mem_rd_i,
  input  logic [XLEN-1:0]  ex_mem_alu_result_i,
  input  logic [XLEN-1:0]  ex_mem_pc_step_i,
  input  logic [XLEN-1:0]  ex_mem_store_data_i,
  mem_wb_stage_if.master   dcache,
  output logic             mem_stall_o,
  output logic             mem_wb_reg_write_o,
  output logic [4:0]       mem_wb_rd_o,
  output logic [XLEN-1:0]  rd_data_o
);

  state_e          state_q, state_d;
  logic            rd_op_q, wr_op_q;
  logic [29:0]     addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] load_buf_q;
  logic            reg_write_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rd_data_q;

  logic            memop;
  logic [XLEN-1:0] wdata_swapped, rdata_swapped;
  logic [XLEN-1:0] wdata_adj, rdata_adj;

  endian_swap #(.XLEN(XLEN)) u_swap_wdata (.data_i(ex_mem_store_data_i), .data_o(wdata_swapped));
  endian_swap #(.XLEN(XLEN)) u_swap_rdata (.data_i(dcache.rdata),        .data_o(rdata_swapped));

  assign wdata_adj = SWAP_ENDIAN ? wdata_swapped : ex_mem_store_data_i;
  assign rdata_adj = SWAP_ENDIAN ? rdata_swapped : dcache.rdata;

  assign memop = ex_mem_valid_i & (ex_mem_mem_read_i | ex_mem_mem_write_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (memop) state_d = ST_ACCESS;
      ST_ACCESS: if (!dcache.stall) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured on launch so the bus stays stable whatever EX/MEM does meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_op_q    <= 1'b0;
      wr_op_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      load_buf_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && memop) begin
        rd_op_q <= ex_mem_mem_read_i;
        wr_op_q <= ex_mem_mem_write_i & ~ex_mem_mem_read_i;
        addr_q  <= ex_mem_alu_result_i[XLEN-1:2];
        wdata_q <= wdata_adj;
      end
      if (state_q == ST_ACCESS && !dcache.stall) begin
        load_buf_q <= rdata_adj;
      end
    end
  end

  assign dcache.ren   = (state_q == ST_ACCESS) & rd_op_q;
  assign dcache.wen   = (state_q == ST_ACCESS) & wr_op_q;
  assign dcache.addr  = addr_q;
  assign dcache.wdata = wdata_q;

  // Gated by rst so every output reads 0 while reset is held, even with a memop waiting.
  assign mem_stall_o = memop & (state_q != ST_DONE) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      rd_data_q   <= '0;
    end else if (mem_stall_o) begin
      reg_write_q <= 1'b0;
    end else begin
      reg_write_q <= ex_mem_valid_i & ex_mem_reg_write_i;
      rd_q        <= ex_mem_rd_i;
      if (ex_mem_memto_reg_i) begin
        rd_data_q <= load_buf_q;
      end else if (ex_mem_jump_i) begin
        rd_data_q <= ex_mem_pc_step_i;
      end else begin
        rd_data_q <= ex_mem_alu_result_i;
      end
    end
  end

  assign mem_wb_reg_write_o = reg_write_q;
  assign mem_wb_rd_o        = rd_q;
  assign rd_data_o          = rd_data_q;

endmodule
